// File: rtl/divider_s_pkg.sv
// Shared constants for the sequential divider: default width, fixed latency
// and the legacy-compatible FSM state encodings.
package divider_s_pkg;

   localparam int DIV_WIDTH   = 32;
   localparam int DIV_LATENCY = DIV_WIDTH + 2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/divider_s_if.sv
// Request/result bundle between the ALU (master) and the divider (slave).
interface divider_s_if #(parameter int WIDTH = divider_s_pkg::DIV_WIDTH);
   import divider_s_pkg::*;

   logic             start;
   logic             sgn;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             dbz;

   modport master (
      output start, sgn, dividend, divisor,
      input  busy, done, quot, rem, dbz
   );

   modport slave (
      input  start, sgn, dividend, divisor,
      output busy, done, quot, rem, dbz
   );

endinterface

// File: rtl/divider_s_div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
   import divider_s_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH:0]   d,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // One guard bit above the shifted remainder so the borrow is a true sign.
   always_comb begin
      shifted = {r, q[WIDTH-1]};
      diff    = shifted - {1'b0, d};
      if (!diff[WIDTH+1]) begin
         r_next = diff[WIDTH:0];
         q_next = {q[WIDTH-2:0], 1'b1};
      end else begin
         r_next = shifted[WIDTH:0];
         q_next = {q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divider_s.sv
// Sequential signed/unsigned divider: one restoring step per clock, start/done
// handshake, fixed WIDTH+2 cycle latency including divide-by-zero.
module divider_s
   import divider_s_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   divider_s_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   r_q;
   logic [WIDTH:0]   d_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] dvd_q;
   logic             neg_a_q;
   logic             neg_b_q;
   logic             dbz_q;
   logic [WIDTH:0]   r_nx;
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;
   logic             dbz_r;

   always_comb begin
      a_abs = (bus.sgn && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
      b_abs = (bus.sgn && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_q),
      .q      (q_q),
      .d      (d_q),
      .r_next (r_nx),
      .q_next (q_nx)
   );

   // CALC spends one extra cycle on count==WIDTH so latency stays WIDTH+2.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         r_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         dvd_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dbz_q   <= 1'b0;
         quot_r  <= '0;
         rem_r   <= '0;
         dbz_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  neg_a_q <= bus.sgn & bus.dividend[WIDTH-1];
                  neg_b_q <= bus.sgn & bus.divisor[WIDTH-1];
                  q_q     <= a_abs;
                  d_q     <= {1'b0, b_abs};
                  dvd_q   <= bus.dividend;
                  dbz_q   <= (bus.divisor == '0);
                  r_q     <= '0;
                  count   <= '0;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (count == CW'(WIDTH)) begin
                  state <= FIX;
               end else begin
                  r_q   <= r_nx;
                  q_q   <= q_nx;
                  count <= count + 1'b1;
               end
            end
            FIX: begin
               if (dbz_q) begin
                  quot_r <= '1;
                  rem_r  <= dvd_q;
               end else begin
                  quot_r <= (neg_a_q ^ neg_b_q) ? -q_q : q_q;
                  rem_r  <= neg_a_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
               end
               dbz_r <= dbz_q;
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.quot = quot_r;
   assign bus.rem  = rem_r;
   assign bus.dbz  = dbz_r;

endmodule

// File: tb/tb_divider_s.sv
// Directed-vector bench for divider_s: results, latency, done width, ignored
// restarts and mid-operation reset.
module tb_divider_s;
   import divider_s_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   divider_s_if #(.WIDTH(32)) bus ();

   divider_s #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] q, output logic [31:0] r,
                         output logic z, output logic one_wide);
      @(negedge clk);
      bus.start = 1'b1; bus.sgn = s; bus.dividend = a; bus.divisor = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.sgn = ~s; bus.dividend = $urandom; bus.divisor = $urandom;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      q = bus.quot; r = bus.rem; z = bus.dbz;
      @(posedge clk); #1;
      one_wide = (bus.done === 1'b0) && (bus.busy === 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.dbz} !== 3'b000 || bus.quot !== 32'h0 || bus.rem !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs busy/done/dbz=%b quot=%h rem=%h required 000/0/0",
                  {bus.busy, bus.done, bus.dbz}, bus.quot, bus.rem);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_signed;
      int lat; logic [31:0] q, r; logic z, p;
      run_op(1'b1, 32'd100, 32'd7, lat, q, r, z, p);
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL latency_100_7 actual=%0d required=34", lat); end
      n_checks++; if (p !== 1'b1) begin n_fail++; $display("FAIL done_width_100_7 actual=%b required=1", p); end
      n_checks++; if ({q, r, z} !== {32'd14, 32'd2, 1'b0}) begin n_fail++;
         $display("FAIL sdiv_100_7 actual=%h/%h/%b required=0000000e/00000002/0", q, r, z); end
      run_op(1'b1, 32'hFFFFFF9C, 32'd7, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0}) begin n_fail++;
         $display("FAIL sdiv_m100_7 actual=%h/%h/%b required=fffffff2/fffffffe/0", q, r, z); end
      run_op(1'b1, 32'd100, 32'hFFFFFFF9, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'hFFFFFFF2, 32'd2, 1'b0}) begin n_fail++;
         $display("FAIL sdiv_100_m7 actual=%h/%h/%b required=fffffff2/00000002/0", q, r, z); end
   endtask

   task automatic test_unsigned;
      int lat; logic [31:0] q, r; logic z, p;
      run_op(1'b0, 32'hFFFFFFFF, 32'd2, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'h7FFFFFFF, 32'd1, 1'b0}) begin n_fail++;
         $display("FAIL udiv_ffffffff_2 actual=%h/%h/%b required=7fffffff/00000001/0", q, r, z); end
      run_op(1'b1, 32'hFFFFFFFF, 32'd2, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'h0, 32'hFFFFFFFF, 1'b0}) begin n_fail++;
         $display("FAIL sdiv_m1_2 actual=%h/%h/%b required=00000000/ffffffff/0", q, r, z); end
   endtask

   task automatic test_dbz;
      int lat; logic [31:0] q, r; logic z, p;
      run_op(1'b0, 32'd123, 32'd0, lat, q, r, z, p);
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL latency_dbz actual=%0d required=34", lat); end
      n_checks++; if ({q, r, z} !== {32'hFFFFFFFF, 32'd123, 1'b1}) begin n_fail++;
         $display("FAIL udbz_123 actual=%h/%h/%b required=ffffffff/0000007b/1", q, r, z); end
      run_op(1'b1, 32'd123, 32'd0, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'hFFFFFFFF, 32'd123, 1'b1}) begin n_fail++;
         $display("FAIL sdbz_123 actual=%h/%h/%b required=ffffffff/0000007b/1", q, r, z); end
      run_op(1'b1, 32'hFFFFFFFB, 32'd0, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1}) begin n_fail++;
         $display("FAIL sdbz_m5 actual=%h/%h/%b required=ffffffff/fffffffb/1", q, r, z); end
   endtask

   task automatic test_min_neg1;
      int lat; logic [31:0] q, r; logic z, p;
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'h80000000, 32'h0, 1'b0}) begin n_fail++;
         $display("FAIL sdiv_min_m1 actual=%h/%h/%b required=80000000/00000000/0", q, r, z); end
      run_op(1'b1, 32'h80000000, 32'd2, lat, q, r, z, p);
      n_checks++; if ({q, r, z} !== {32'hC0000000, 32'h0, 1'b0}) begin n_fail++;
         $display("FAIL sdiv_min_2 actual=%h/%h/%b required=c0000000/00000000/0", q, r, z); end
   endtask

   task automatic test_back_to_back;
      int ndone = 0;
      int at = 0;
      int lat;
      logic [31:0] q = '0, r = '0;
      logic z, p;
      @(negedge clk);
      bus.start = 1'b1; bus.sgn = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'hFFFFFFF7;
      @(posedge clk); #1;
      for (int e = 1; e <= 60; e++) begin
         if (e == 5 || e == 20) begin
            bus.start = 1'b1; bus.sgn = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin at = e; q = bus.quot; r = bus.rem; end
         end
      end
      n_checks++; if (ndone !== 1 || at !== 34) begin n_fail++;
         $display("FAIL restart_done_count actual=%0d@%0d required=1@34", ndone, at); end
      n_checks++; if ({q, r} !== {32'hFFFFFF91, 32'd1}) begin n_fail++;
         $display("FAIL restart_result actual=%h/%h required=ffffff91/00000001", q, r); end
      run_op(1'b0, 32'd50, 32'd5, lat, q, r, z, p);
      n_checks++; if (lat !== 34 || {q, r, z} !== {32'd10, 32'd0, 1'b0}) begin n_fail++;
         $display("FAIL after_restart lat=%0d result=%h/%h/%b required=34 0000000a/00000000/0", lat, q, r, z); end
   endtask

   task automatic test_reset_mid_op;
      int ndone = 0;
      int lat;
      logic [31:0] q, r; logic z, p;
      @(negedge clk);
      bus.start = 1'b1; bus.sgn = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.dbz} !== 3'b000 || bus.quot !== 32'h0 || bus.rem !== 32'h0) begin
         n_fail++;
         $display("FAIL midop_reset busy/done/dbz=%b quot=%h rem=%h required 000/0/0",
                  {bus.busy, bus.done, bus.dbz}, bus.quot, bus.rem);
      end
      rst = 1'b0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      end
      n_checks++; if (ndone !== 0) begin n_fail++;
         $display("FAIL aborted_activity actual=%0d cycles required=0", ndone); end
      run_op(1'b0, 32'd9, 32'd3, lat, q, r, z, p);
      n_checks++; if (lat !== 34 || {q, r, z} !== {32'd3, 32'd0, 1'b0}) begin n_fail++;
         $display("FAIL post_reset_9_3 lat=%0d result=%h/%h/%b required=34 00000003/00000000/0", lat, q, r, z); end
   endtask

   initial begin
      bus.start = 1'b0; bus.sgn = 1'b0; bus.dividend = '0; bus.divisor = '0;
      test_reset();
      test_signed();
      test_unsigned();
      test_dbz();
      test_min_neg1();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
